cfg_writer: RTL

CFG_WRITER -- requirements
Module: cfg_writer

---
 rtl/cfg_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cfg_writer.sv
// cfg_writer: AXI4-Lite slave that assembles NUM_WORDS 32-bit registers into one packed cfg_data word.
// Define CFG_WRITER_READBACK_EN to return cfg_data words on reads; otherwise every read returns SLVERR.
module cfg_writer #(
    parameter int CFG_DATA_WIDTH = 160,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [CFG_DATA_WIDTH-1:0] cfg_data,
    output logic                      cfg_update
);
    localparam int NUM_WORDS = CFG_DATA_WIDTH / 32;
    localparam int IW        = AXI_ADDR_WIDTH - 2;

    logic                      aw_held_q;
    logic [IW-1:0]             aw_idx_q;
    logic                      w_held_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic                      rvalid_q;
    logic [1:0]                rresp_q;
    logic [CFG_DATA_WIDTH-1:0] cfg_q;
    logic [CFG_DATA_WIDTH-1:0] cfg_d;
    logic                      cfg_update_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          wr_fire;
    logic          wr_in_range;
    logic [1:0]    rd_resp;
    logic          unused_addr_bits;

    // Readies are gated by arst so they read 0 throughout reset and rise as soon as it is released.
    assign s_axi_awready = ~arst & ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~arst & ~w_held_q & ~bvalid_q;
    assign s_axi_arready = ~arst & ~rvalid_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    assign wr_idx      = aw_held_q ? aw_idx_q : s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
    assign wr_data     = w_held_q ? wdata_q : s_axi_wdata;
    assign wr_strb     = w_held_q ? wstrb_q : s_axi_wstrb;
    assign wr_fire     = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_in_range = 32'(wr_idx) < NUM_WORDS;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (32'(wr_idx) == 32'(k) && wr_strb[b]) begin
                        cfg_d[32*k+8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef CFG_WRITER_READBACK_EN
    logic [IW-1:0] rd_idx;
    logic          rd_in_range;
    logic [31:0]   rd_word;
    logic [31:0]   rdata_q;

    assign rd_idx      = s_axi_araddr[AXI_ADDR_WIDTH-1:2];
    assign rd_in_range = 32'(rd_idx) < NUM_WORDS;
    assign rd_resp     = rd_in_range ? 2'b00 : 2'b10;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (32'(rd_idx) == 32'(k)) begin
                rd_word = cfg_q[32*k +: 32];
            end
        end
    end

    // Sampled from cfg_q, so a read racing a write to the same word sees the old value.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rdata_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= rd_in_range ? rd_word : 32'd0;
        end
    end

    assign s_axi_rdata      = rdata_q;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign rd_resp          = 2'b10;
    assign s_axi_rdata      = '0;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr};
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            aw_held_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            cfg_q        <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            cfg_update_q <= wr_fire & wr_in_range;
            if (wr_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_range ? 2'b00 : 2'b10;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_axi_wdata;
                    wstrb_q  <= s_axi_wstrb;
                end
                if (bvalid_q && s_axi_bready) begin
                    bvalid_q <= 1'b0;
                end
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign cfg_data     = cfg_q;
    assign cfg_update   = cfg_update_q;
endmodule
